sram_rr_ctrl: RTL and testbench

Two-port round-robin controller in front of the single-port `sram_8w_16d_4rx` array. After reset it runs a zero-fill sweep of the whole array in training mode. It then arbitrates read/write requests from two requesters onto the one SRAM port, returning read data per port. Every SRAM control line is driven from registers.

---
 rtl/sram_rr_ctrl_pkg.sv | 20 ++
 rtl/sram_rr_ctrl_arb.sv | 37 +++
 rtl/sram_rr_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sram_rr_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rr_ctrl_pkg.sv
// Shared types and default sizing for the round-robin SRAM front-end.
package sram_ctrl_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int ADDR_DEF  = 16;

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_e;

    // Travels with each read so the returning word lands on its owner's port.
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } rd_tag_t;

endpackage

// File: rtl/sram_rr_ctrl_arb.sv
// Two-requester round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_q, last_d;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        last_d = last_q;
        if (en) begin
            // On a tie the port that was not granted last wins.
            if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Zero-fill sweep after reset, then round-robin read/write service of two ports
// onto one registered SRAM port with a two-stage read-return pipeline.
//
// state    | meaning
// ST_INIT  | writing zeros to addresses 0..DEPTH-1, one per cycle, train mode
// ST_SERVE | arbitrating p0/p1 requests onto the SRAM
module sram_rr_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR  = ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [ADDR-1:0]  p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [ADDR-1:0]  p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             sram_wren,
    output logic             sram_rden,
    output logic             sram_boot_mode,
    output logic             sram_train_mode,
    output logic [ADDR-1:0]  sram_addr,
    output logic [WIDTH-1:0] sram_data_in,
    input  logic [WIDTH-1:0] sram_data_out,
    output logic             init_done,
    output logic             addr_err
);

    state_e           state_q, state_d;
    logic [ADDR-1:0]  cnt_q, cnt_d;
    logic             wren_q, wren_d, rden_q, rden_d;
    logic             boot_q, boot_d, train_q, train_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             err_q, err_d, done_q, done_d;
    logic             rv0_q, rv0_d, rv1_q, rv1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    rd_tag_t          tag1_q, tag1_d, tag2_q, tag2_d;

    logic             arb_en, arb_g0, arb_g1;
    logic             sel_we, sel_oob;
    logic [ADDR-1:0]  sel_addr;
    logic [WIDTH-1:0] sel_wdata, rd_word;

    assign arb_en = (state_q == ST_SERVE);

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (p0_req),
        .req1 (p1_req),
        .gnt0 (arb_g0),
        .gnt1 (arb_g1)
    );

    always_comb begin
        sel_we    = arb_g1 ? p1_we    : p0_we;
        sel_addr  = arb_g1 ? p1_addr  : p0_addr;
        sel_wdata = arb_g1 ? p1_wdata : p0_wdata;
        sel_oob   = (sel_addr >= ADDR'(DEPTH));
        rd_word   = tag2_q.err ? '0 : sram_data_out;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        boot_d   = 1'b0;
        train_d  = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        err_d    = 1'b0;
        done_d   = (state_q == ST_SERVE);
        tag1_d   = '0;
        tag2_d   = tag1_q;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_INIT: begin
                wren_d  = 1'b1;
                train_d = 1'b1;
                addr_d  = cnt_q;
                din_d   = '0;
                cnt_d   = cnt_q + ADDR'(1);
                if (cnt_q == ADDR'(DEPTH - 1)) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            ST_SERVE: begin
                if (arb_g0 || arb_g1) begin
                    gnt0_d = arb_g0;
                    gnt1_d = arb_g1;
                    err_d  = sel_oob;
                    // Out-of-range requests are acknowledged but never reach the array.
                    if (!sel_oob) begin
                        addr_d = sel_addr;
                        if (sel_we) begin
                            wren_d = 1'b1;
                            din_d  = sel_wdata;
                        end else begin
                            rden_d = 1'b1;
                            boot_d = 1'b1;
                        end
                    end
                    tag1_d.valid = ~sel_we;
                    tag1_d.port  = arb_g1;
                    tag1_d.err   = sel_oob;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (tag2_q.valid) begin
            if (tag2_q.port) begin
                rv1_d    = 1'b1;
                rdata1_d = rd_word;
            end else begin
                rv0_d    = 1'b1;
                rdata0_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            boot_q   <= 1'b0;
            train_q  <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            boot_q   <= boot_d;
            train_q  <= train_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign sram_wren       = wren_q;
    assign sram_rden       = rden_q;
    assign sram_boot_mode  = boot_q;
    assign sram_train_mode = train_q;
    assign sram_addr       = addr_q;
    assign sram_data_in    = din_q;
    assign p0_gnt          = gnt0_q;
    assign p1_gnt          = gnt1_q;
    assign addr_err        = err_q;
    assign init_done       = done_q;
    assign p0_rvalid       = rv0_q;
    assign p1_rvalid       = rv1_q;
    assign p0_rdata        = rdata0_q;
    assign p1_rdata        = rdata1_q;

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Directed plus random bench for sram_rr_ctrl against a cycle-level rule model.
module tb_sram_rr_ctrl;

    logic        clk, rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        sram_wren, sram_rden, sram_boot_mode, sram_train_mode;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data_in, sram_data_out;
    logic        init_done, addr_err;

    sram_rr_ctrl dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_wren(sram_wren), .sram_rden(sram_rden), .sram_boot_mode(sram_boot_mode),
        .sram_train_mode(sram_train_mode), .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out), .init_done(init_done), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port array: read data valid the cycle after rden.
    logic [7:0] smem [16];
    always @(posedge clk) begin
        if (sram_wren && sram_addr < 16'd16) smem[sram_addr[3:0]] <= sram_data_in;
        if (sram_rden) sram_data_out <= smem[sram_addr[3:0]];
    end

    typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } txn_t;
    typedef struct { int due; int port; logic [7:0] data; } ret_t;

    int errors = 0;
    int checks = 0;

    int         n;
    bit         lp;
    logic [7:0] refmem [16];
    ret_t       rq [$];
    logic       e_g0, e_g1, e_err, e_rv0, e_rv1, e_done;
    logic       e_wren, e_rden, e_boot, e_train;
    logic [15:0] e_addr;
    logic [7:0]  e_din, e_rd0, e_rd1;

    txn_t q0 [$];
    txn_t q1 [$];
    bit   fl0, fl1, gn0, gn1;

    function automatic txn_t mk(input logic we, input int a, input int d);
        txn_t t;
        t.we = we; t.addr = 16'(a); t.wdata = 8'(d);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the controller's rules to the inputs sampled at this rising edge.
    task automatic model_edge();
        ret_t r;
        int w;
        logic [15:0] a;
        logic we;
        logic [7:0] d;
        bit oob;
        {e_g0, e_g1, e_err, e_rv0, e_rv1, e_wren, e_rden, e_boot} = '0;
        gn0 = 0; gn1 = 0;
        if (rst) begin
            n = 0; lp = 1; rq.delete();
            e_done = 0; e_train = 0; e_addr = 0; e_din = 0; e_rd0 = 0; e_rd1 = 0;
            return;
        end
        n++;
        if (rq.size() > 0 && rq[0].due == n) begin
            r = rq.pop_front();
            if (r.port == 1) begin e_rv1 = 1; e_rd1 = r.data; end
            else             begin e_rv0 = 1; e_rd0 = r.data; end
        end
        if (n <= 16) begin
            e_wren = 1; e_train = 1; e_done = 0;
            e_addr = 16'(n - 1); e_din = 0;
            refmem[n - 1] = 8'h00;
        end else begin
            e_done = 1; e_train = 0;
            if (p0_req && p1_req) w = lp ? 0 : 1;
            else if (p0_req)      w = 0;
            else if (p1_req)      w = 1;
            else                  w = -1;
            if (w >= 0) begin
                lp  = (w == 1);
                we  = (w == 1) ? p1_we    : p0_we;
                a   = (w == 1) ? p1_addr  : p0_addr;
                d   = (w == 1) ? p1_wdata : p0_wdata;
                oob = (a >= 16'd16);
                if (w == 1) begin e_g1 = 1; gn1 = 1; end
                else        begin e_g0 = 1; gn0 = 1; end
                e_err = oob;
                if (we) begin
                    if (!oob) begin e_wren = 1; e_addr = a; e_din = d; refmem[a[3:0]] = d; end
                end else begin
                    r.due = n + 2; r.port = w; r.data = oob ? 8'h00 : refmem[a[3:0]];
                    rq.push_back(r);
                    if (!oob) begin e_rden = 1; e_boot = 1; e_addr = a; end
                end
            end
        end
    endtask

    task automatic present();
        p0_req = (q0.size() > 0);
        if (q0.size() > 0) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata; end
        p1_req = (q1.size() > 0);
        if (q1.size() > 0) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata; end
    endtask

    // A granted request is held through its grant cycle, then retired.
    task automatic drive();
        if (fl0) begin q0.delete(0); fl0 = 0; end
        else if (gn0) fl0 = 1;
        if (fl1) begin q1.delete(0); fl1 = 0; end
        else if (gn1) fl1 = 1;
        present();
    endtask

    task automatic check_all();
        chk("ctl", {26'b0, p0_gnt, p1_gnt, addr_err, p0_rvalid, p1_rvalid, init_done},
                   {26'b0, e_g0, e_g1, e_err, e_rv0, e_rv1, e_done});
        chk("strobes", {28'b0, sram_wren, sram_rden, sram_boot_mode, sram_train_mode},
                       {28'b0, e_wren, e_rden, e_boot, e_train});
        chk("sram_addr", {16'b0, sram_addr}, {16'b0, e_addr});
        chk("sram_data_in", {24'b0, sram_data_in}, {24'b0, e_din});
        chk("p0_rdata", {24'b0, p0_rdata}, {24'b0, e_rd0});
        chk("p1_rdata", {24'b0, p1_rdata}, {24'b0, e_rd1});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        drive();
    endtask

    task automatic run_idle(input int budget);
        int c = 0;
        while ((q0.size() > 0 || q1.size() > 0) && c < budget) begin
            step();
            c++;
        end
        chk("drain_budget", {31'b0, c < budget}, 32'd1);
        repeat (4) step();
    endtask

    function automatic txn_t rnd_txn();
        int r = $urandom_range(0, 19);
        int a;
        if (r < 16)       a = r;
        else if (r == 16) a = 16;
        else if (r == 17) a = 16'hFFFF;
        else              a = $urandom_range(17, 65535);
        return mk(1'($urandom_range(0, 1)), a, $urandom_range(0, 255));
    endfunction

    initial begin
        int c;
        rst = 1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        fl0 = 0; fl1 = 0; gn0 = 0; gn1 = 0;
        @(negedge clk);
        repeat (3) step();

        // Both ports requesting across the whole sweep: first tie goes to p0.
        q0.push_back(mk(0, 5, 0));
        q1.push_back(mk(0, 6, 0));
        present();
        rst = 0;
        run_idle(60);

        for (int a = 0; a < 16; a++) q0.push_back(mk(0, a, 0));
        present();
        run_idle(100);

        q0.push_back(mk(1, 3, 8'hA5));
        q0.push_back(mk(0, 3, 0));
        present();
        run_idle(40);

        foreach (q0[i]) q0.delete(i);
        q0.push_back(mk(0, 3, 0)); q0.push_back(mk(0, 1, 0));
        q0.push_back(mk(0, 2, 0)); q0.push_back(mk(0, 4, 0));
        q1.push_back(mk(0, 3, 0)); q1.push_back(mk(0, 5, 0));
        q1.push_back(mk(0, 6, 0)); q1.push_back(mk(0, 7, 0));
        present();
        run_idle(60);

        q0.push_back(mk(1, 9, 8'h5A)); q1.push_back(mk(0, 9, 0));
        q1.push_back(mk(1, 9, 8'hC3)); q0.push_back(mk(0, 9, 0));
        present();
        run_idle(40);

        q1.push_back(mk(0, 16'h0010, 0));
        q1.push_back(mk(1, 16'hFFFF, 8'h77));
        q0.push_back(mk(0, 16'h8000, 0));
        q0.push_back(mk(0, 15, 0));
        present();
        run_idle(40);

        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 3) != 0) q0.push_back(rnd_txn());
            if (q1.size() < 2 && $urandom_range(0, 3) != 0) q1.push_back(rnd_txn());
            present();
            step();
        end
        run_idle(200);

        // Reset one cycle after a read grant: nothing may come back.
        q0.push_back(mk(0, 9, 0));
        present();
        c = 0;
        while (!gn0 && c < 10) begin step(); c++; end
        chk("mid_read_gnt_budget", {31'b0, c < 10}, 32'd1);
        step();
        rst = 1;
        #1;
        chk("async_rst_ctl", {20'b0, p0_gnt, p1_gnt, addr_err, p0_rvalid, p1_rvalid, init_done,
                              sram_wren, sram_rden, sram_boot_mode, sram_train_mode, 2'b0}, 32'd0);
        chk("async_rst_data", {sram_addr, sram_data_in, p0_rdata | p1_rdata}, 32'd0);
        q0.delete(); q1.delete(); fl0 = 0; fl1 = 0;
        present();
        step();
        step();
        rst = 0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
